ps2_key_fifo: RTL and testbench

PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

---
 rtl/ps2_key_fifo.sv | 130 +++++++++++++
 tb/tb_ps2_key_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: buffers HPS_IO key events and replays them at a controlled pace.
// An input event is a flip of ps2_key_in[10]. Each event's 10-bit payload is
// queued, and events are released on ps2_key_out at least GAP clk_sys cycles
// apart. A dropped event sets the sticky overflow flag.
module ps2_key_fifo #(
    parameter int DEPTH = 8,   // entry count, power of two, 2..64
    parameter int GAP   = 16   // minimum cycles between output events, 1..255
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [10:0]              ps2_key_in,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic [10:0]              ps2_key_out,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    gap_cnt;
    logic          prev_t;
    logic          armed;

    logic          in_evt;
    logic          full;
    logic          pop;
    logic          push;
    logic          do_push;
    logic          drop;

    // Event detection and push/pop arbitration for the current cycle.
    always_comb begin
        // NOTE: every signal gets a default before any condition so no latch is inferred.
        in_evt  = 1'b0;
        full    = 1'b0;
        pop     = 1'b0;
        push    = 1'b0;
        do_push = 1'b0;
        drop    = 1'b0;

        in_evt  = armed && (ps2_key_in[10] != prev_t);
        full    = (level == LW'(DEPTH));
        // Flush wins over both sides of the FIFO in its cycle.
        pop     = !flush && (level != '0) && (gap_cnt == 8'd0);
        push    = in_evt && !flush;
        // When full, a simultaneous pop frees the slot that the push reuses.
        do_push = push && (!full || pop);
        drop    = push && full && !pop;
    end

    // Toggle tracking: the first edge after reset only samples the toggle bit,
    // so a stale toggle level left over from before reset is never taken as an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            prev_t <= 1'b0;
            armed  <= 1'b0;
        end else if (!armed) begin
            prev_t <= ps2_key_in[10];
            armed  <= 1'b1;
        end else if (in_evt) begin
            // Consumed even when flushed or dropped.
            prev_t <= ps2_key_in[10];
        end
    end

    // Payload storage.
    always_ff @(posedge clk_sys) begin
        // NOTE: the storage array has no reset; pointers and level define which entries are valid.
        if (do_push) begin
            mem[wr_ptr] <= ps2_key_in[9:0];
        end
    end

    // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Output stage and pacing: a pop presents the head entry, flips the
    // output toggle and restarts the gap counter.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ps2_key_out <= 11'h000;
            gap_cnt     <= 8'd0;
        end else if (pop) begin
            ps2_key_out <= {~ps2_key_out[10], mem[rd_ptr]};
            gap_cnt     <= 8'(GAP - 1);
        end else if (gap_cnt != 8'd0) begin
            gap_cnt     <= gap_cnt - 8'd1;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb_ps2_key_fifo: directed bench for ps2_key_fifo (DEPTH=8, GAP=16).
// Inputs change 1 time unit after a rising edge; a negedge monitor logs every
// output toggle together with the index of the rising edge that produced it.
module tb_ps2_key_fifo;

    localparam int DEPTH = 8;
    localparam int GAP   = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key_in = 11'h400;
    logic        flush = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [10:0] ps2_key_out;
    logic        overflow;
    logic [3:0]  level;

    ps2_key_fifo #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key_in  (ps2_key_in),
        .flush       (flush),
        .clr_ovf     (clr_ovf),
        .ps2_key_out (ps2_key_out),
        .overflow    (overflow),
        .level       (level)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          cyc;
        logic [10:0] d;
    } rec_t;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    rec_t recs[$];
    logic last_t = 1'b0;
    logic tog = 1'b1;     // current ps2_key_in[10]
    logic exp_t = 1'b0;   // toggle bit expected on the next output event

    logic [9:0] burst_codes [5] = '{10'h21C, 10'h032, 10'h321, 10'h0F0, 10'h2AA};
    logic [9:0] ovf_codes  [10] = '{10'h201, 10'h002, 10'h203, 10'h104, 10'h205,
                                    10'h006, 10'h307, 10'h008, 10'h209, 10'h3FF};

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Log each output toggle with the rising-edge index that caused it.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            last_t = 1'b0;
        end else if (ps2_key_out[10] !== last_t) begin
            recs.push_back('{cyc, ps2_key_out});
            last_t = ps2_key_out[10];
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one input event; it is captured at the next rising edge.
    task automatic send_evt(input logic [9:0] d);
        tog = ~tog;
        ps2_key_in = {tog, d};
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ps2_key_in = 11'h400;
        tog = 1'b1;
        idle(3);
        checks++;
        if (ps2_key_out !== 11'h000) begin
            errors++; $display("FAIL reset_out: got %h expected 000", ps2_key_out);
        end
        checks++;
        if (overflow !== 1'b0 || level !== 4'd0) begin
            errors++; $display("FAIL reset_flags: got ovf=%b level=%0d expected ovf=0 level=0", overflow, level);
        end
        reset_n = 1'b1;
        recs.delete();
        idle(100);
        checks++;
        if (recs.size() != 0) begin
            errors++; $display("FAIL reset_stale_toggle: got %0d output events expected 0", recs.size());
        end
        checks++;
        if (level !== 4'd0) begin
            errors++; $display("FAIL reset_level: got %0d expected 0", level);
        end
    endtask

    task automatic test_single();
        int t0;
        recs.delete();
        t0 = cyc;
        send_evt(10'h21C);
        idle(4);
        exp_t = ~exp_t;
        checks++;
        if (recs.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d expected 1", recs.size());
        end else begin
            checks++;
            if (recs[0].d !== 11'h61C) begin
                errors++; $display("FAIL single_data: got %h expected 61c", recs[0].d);
            end
            checks++;
            if (recs[0].cyc != t0 + 2) begin
                errors++; $display("FAIL single_latency: got edge %0d expected %0d", recs[0].cyc, t0 + 2);
            end
        end
        checks++;
        if (level !== 4'd0) begin
            errors++; $display("FAIL single_level: got %0d expected 0", level);
        end
    endtask

    task automatic test_burst();
        int t0;
        int peak;
        idle(GAP + 4);
        recs.delete();
        peak = 0;
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            send_evt(burst_codes[i]);
            if (int'(level) > peak) peak = int'(level);
        end
        for (int i = 0; i < 5 * GAP + 10; i++) begin
            tick();
            if (int'(level) > peak) peak = int'(level);
        end
        checks++;
        if (peak != 4) begin
            errors++; $display("FAIL burst_peak_level: got %0d expected 4", peak);
        end
        checks++;
        if (recs.size() != 5) begin
            errors++; $display("FAIL burst_count: got %0d expected 5", recs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_t = ~exp_t;
                checks++;
                if (recs[i].d !== {exp_t, burst_codes[i]}) begin
                    errors++; $display("FAIL burst_data[%0d]: got %h expected %h", i, recs[i].d, {exp_t, burst_codes[i]});
                end
                checks++;
                if (recs[i].cyc != t0 + 2 + i * GAP) begin
                    errors++; $display("FAIL burst_spacing[%0d]: got edge %0d expected %0d", i, recs[i].cyc, t0 + 2 + i * GAP);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int t0;
        idle(GAP + 4);
        recs.delete();
        t0 = cyc;
        for (int i = 0; i < 10; i++) send_evt(ovf_codes[i]);
        checks++;
        if (overflow !== 1'b1 || level !== 4'd8) begin
            errors++; $display("FAIL ovf_set: got ovf=%b level=%0d expected ovf=1 level=8", overflow, level);
        end
        idle(9 * GAP + 10);
        checks++;
        if (recs.size() != 9) begin
            errors++; $display("FAIL ovf_count: got %0d expected 9", recs.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                exp_t = ~exp_t;
                checks++;
                if (recs[i].d !== {exp_t, ovf_codes[i]} || recs[i].cyc != t0 + 2 + i * GAP) begin
                    errors++;
                    $display("FAIL ovf_order[%0d]: got %h at edge %0d expected %h at edge %0d",
                             i, recs[i].d, recs[i].cyc, {exp_t, ovf_codes[i]}, t0 + 2 + i * GAP);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_flush();
        int t0;
        idle(GAP + 4);
        recs.delete();
        send_evt(10'h111);
        send_evt(10'h122);
        send_evt(10'h133);
        send_evt(10'h144);
        checks++;
        if (level !== 4'd3) begin
            errors++; $display("FAIL flush_fill_level: got %0d expected 3", level);
        end
        // Flush together with a new input event.
        tog = ~tog;
        ps2_key_in = {tog, 10'h155};
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (level !== 4'd0) begin
            errors++; $display("FAIL flush_level: got %0d expected 0", level);
        end
        idle(60);
        exp_t = ~exp_t;
        checks++;
        if (recs.size() != 1 || recs[0].d !== {exp_t, 10'h111}) begin
            errors++; $display("FAIL flush_no_output: got %0d events expected only first event (%h)", recs.size(), {exp_t, 10'h111});
        end
        recs.delete();
        t0 = cyc;
        send_evt(10'h2E5);
        idle(4);
        exp_t = ~exp_t;
        checks++;
        if (recs.size() != 1 || recs[0].d !== {exp_t, 10'h2E5} || recs[0].cyc != t0 + 2) begin
            errors++; $display("FAIL flush_after_event: got %0d events expected %h at edge %0d", recs.size(), {exp_t, 10'h2E5}, t0 + 2);
        end
    endtask

    task automatic test_reset_mid();
        idle(GAP + 4);
        for (int i = 0; i < 7; i++) send_evt(10'(10'h040 + i));
        checks++;
        if (level !== 4'd6) begin
            errors++; $display("FAIL mid_fill_level: got %0d expected 6", level);
        end
        // Assert reset between clock edges and check before the next edge.
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ps2_key_out !== 11'h000 || level !== 4'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_async_reset: got out=%h level=%0d ovf=%b expected 000 0 0", ps2_key_out, level, overflow);
        end
        tog = 1'b1;
        ps2_key_in = 11'h400;
        idle(3);
        reset_n = 1'b1;
        exp_t = 1'b0;
        recs.delete();
        idle(100);
        checks++;
        if (recs.size() != 0 || level !== 4'd0) begin
            errors++; $display("FAIL mid_no_stale_events: got %0d events level=%0d expected 0 events level=0", recs.size(), level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
